// File: rtl/rtype_exec_unit.sv
// R-type execute stage: register file, single-cycle ALU, iterative MUL/DIV.
// Optional signed-overflow trap on ADD/SUB is enabled by defining OVF_TRAP_EN.

module rtype_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  localparam int REG_AW = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic [REG_AW-1:0] rs_num,
  input  logic [REG_AW-1:0] rt_num,
  input  logic [REG_AW-1:0] rd_num,
  input  logic [4:0]        sh_amount,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_num,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              illegal_op,
  output logic              halted,
  input  logic [REG_AW-1:0] dbg_num,
  output logic [DATA_W-1:0] dbg_data
`ifdef OVF_TRAP_EN
  ,
  output logic              ovf_trap,
  output logic [15:0]       ovf_count
`endif
);

  // state  | meaning
  // S_IDLE | accepting instructions, single-cycle ops complete here
  // S_ITER | MUL/DIV running one bit per edge
  // S_HALT | SYSCALL seen, frozen until rst

  localparam int MSB   = DATA_W - 1;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_SYS = 6'h0C;
  localparam logic [5:0] F_MUL = 6'h18;
  localparam logic [5:0] F_DIV = 6'h1A;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_HALT} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] regs [REG_NUM];
  logic [DATA_W-1:0] rs_val, rt_val, sum, diff, alu_res;
  logic [4:0]        sh_mod;
  logic              accept, legal, is_iter, is_sys, ovf_hit;

  logic [DATA_W:0]   acc, acc_nx, rem_sh;
  logic [DATA_W-1:0] opa, opa_nx, opb, opb_nx, iter_res;
  logic [CNT_W-1:0]  cnt;
  logic              is_div, div_ge;
  logic [REG_AW-1:0] iter_rd;

  logic              we;
  logic [REG_AW-1:0] wnum;
  logic [DATA_W-1:0] wdata;

  assign rs_val   = (rs_num == '0)  ? '0 : regs[rs_num];
  assign rt_val   = (rt_num == '0)  ? '0 : regs[rt_num];
  assign dbg_data = (dbg_num == '0) ? '0 : regs[dbg_num];
  assign sum      = rs_val + rt_val;
  assign diff     = rs_val - rt_val;
  assign sh_mod   = 5'(int'(sh_amount) % DATA_W);

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state == S_ITER);
  assign halted      = (state == S_HALT);
  assign accept      = instr_valid && (state == S_IDLE);

`ifdef OVF_TRAP_EN
  logic add_ovf, sub_ovf;
  assign add_ovf = (rs_val[MSB] == rt_val[MSB]) && (sum[MSB]  != rs_val[MSB]);
  assign sub_ovf = (rs_val[MSB] != rt_val[MSB]) && (diff[MSB] != rs_val[MSB]);
  assign ovf_hit = accept && (opcode == 6'h00) &&
                   (((func == F_ADD) && add_ovf) || ((func == F_SUB) && sub_ovf));
`else
  assign ovf_hit = 1'b0;
`endif

  // decode, ALU and next state
  always_comb begin
    state_nx = state;
    legal    = 1'b0;
    is_iter  = 1'b0;
    is_sys   = 1'b0;
    alu_res  = '0;
    if (opcode == 6'h00) begin
      legal = 1'b1;
      case (func)
        F_ADD:        alu_res = sum;
        F_SUB:        alu_res = diff;
        F_AND:        alu_res = rs_val & rt_val;
        F_OR:         alu_res = rs_val | rt_val;
        F_XOR:        alu_res = rs_val ^ rt_val;
        F_NOR:        alu_res = ~(rs_val | rt_val);
        F_SLL:        alu_res = rt_val << sh_mod;
        F_SRL:        alu_res = rt_val >> sh_mod;
        F_SRA:        alu_res = $signed(rt_val) >>> sh_mod;
        F_MUL, F_DIV: is_iter = 1'b1;
        F_SYS:        is_sys  = 1'b1;
        default:      legal   = 1'b0;
      endcase
    end
    case (state)
      S_IDLE: begin
        if (accept && legal && is_iter)     state_nx = S_ITER;
        else if (accept && legal && is_sys) state_nx = S_HALT;
      end
      S_ITER:  if (cnt == CNT_LAST) state_nx = S_IDLE;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  // one step of shift-add multiply or restoring divide
  always_comb begin
    rem_sh = {acc[DATA_W-1:0], opb[MSB]};
    div_ge = (rem_sh >= {1'b0, opa});
    if (is_div) begin
      acc_nx = div_ge ? (rem_sh - {1'b0, opa}) : rem_sh;
      opa_nx = opa;
      opb_nx = {opb[DATA_W-2:0], div_ge};
      iter_res = opb_nx;
    end else begin
      acc_nx = opb[0] ? (acc + {1'b0, opa}) : acc;
      opa_nx = opa << 1;
      opb_nx = opb >> 1;
      iter_res = acc_nx[DATA_W-1:0];
    end
  end

  always_comb begin
    we    = 1'b0;
    wnum  = rd_num;
    wdata = alu_res;
    if (state == S_ITER) begin
      if (cnt == CNT_LAST) begin
        we    = 1'b1;
        wnum  = iter_rd;
        wdata = iter_res;
      end
    end else if (accept && legal && !is_iter && !is_sys && !ovf_hit) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      wb_valid   <= 1'b0;
      wb_num     <= '0;
      wb_data    <= '0;
      illegal_op <= 1'b0;
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      cnt        <= '0;
      is_div     <= 1'b0;
      iter_rd    <= '0;
    end else begin
      if (we && (wnum != '0)) regs[wnum] <= wdata;
      wb_valid   <= we;
      if (we) begin
        wb_num  <= wnum;
        wb_data <= wdata;
      end
      illegal_op <= accept && !legal;
      if (accept && legal && is_iter) begin
        // divide keeps the divisor in opa and shifts the dividend out of opb
        is_div  <= (func == F_DIV);
        opa     <= (func == F_DIV) ? rt_val : rs_val;
        opb     <= (func == F_DIV) ? rs_val : rt_val;
        acc     <= '0;
        cnt     <= '0;
        iter_rd <= rd_num;
      end else if (state == S_ITER) begin
        acc <= acc_nx;
        opa <= opa_nx;
        opb <= opb_nx;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef OVF_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_trap  <= 1'b0;
      ovf_count <= '0;
    end else begin
      ovf_trap <= ovf_hit;
      if (ovf_hit && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rtype_exec_unit.sv
// Directed bench for rtype_exec_unit (DATA_W=32, REG_NUM=32); covers OVF_TRAP_EN when defined.

module tb_rtype_exec_unit;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_SYS = 6'h0C;
  localparam logic [5:0] F_MUL = 6'h18;
  localparam logic [5:0] F_DIV = 6'h1A;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;

  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready;
  logic [5:0]  opcode, func;
  logic [4:0]  rs_num, rt_num, rd_num, sh_amount, wb_num, dbg_num;
  logic        wb_valid, busy, illegal_op, halted;
  logic [31:0] wb_data, dbg_data;
`ifdef OVF_TRAP_EN
  logic        ovf_trap;
  logic [15:0] ovf_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int seen;

  always #5 clk = ~clk;

  rtype_exec_unit #(.DATA_W(32), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .func(func),
    .rs_num(rs_num), .rt_num(rt_num), .rd_num(rd_num), .sh_amount(sh_amount),
    .wb_valid(wb_valid), .wb_num(wb_num), .wb_data(wb_data),
    .busy(busy), .illegal_op(illegal_op), .halted(halted),
    .dbg_num(dbg_num), .dbg_data(dbg_data)
`ifdef OVF_TRAP_EN
    , .ovf_trap(ovf_trap), .ovf_count(ovf_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] n, input logic [31:0] exp);
    dbg_num = n;
    #1;
    check(tag, {32'd0, dbg_data}, {32'd0, exp});
  endtask

  task automatic send(input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh);
    opcode = op; func = fn; rs_num = rs; rt_num = rt; rd_num = rd; sh_amount = sh;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh);
    send(6'h00, fn, rs, rt, rd, sh);
  endtask

  task automatic wait_iter(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic watch_wb(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (wb_valid) hits++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; func = '0;
    rs_num = '0; rt_num = '0; rd_num = '0; sh_amount = '0; dbg_num = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", instr_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_num", wb_num, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_halted", halted, 0);

    // preload r1=5, r2=7 from zeros
    rtype(F_NOR, 0, 0, 1, 0);   // r1 = ffffffff
    rtype(F_SRL, 0, 1, 2, 29);  // r2 = 7
    rtype(F_SRL, 0, 1, 8, 31);  // r8 = 1
    rtype(F_SLL, 0, 8, 9, 1);   // r9 = 2
    rtype(F_XOR, 2, 9, 1, 0);   // r1 = 5
    check("preload_r1", wb_data, 5);
    rtype(F_ADD, 1, 2, 3, 0);
    check("add_wb_valid", wb_valid, 1);
    check("add_wb_num", wb_num, 3);
    check("add_wb_data", wb_data, 12);
    check_reg("add_dbg_r3", 3, 32'd12);

    rtype(F_SLL, 0, 8, 1, 31);  // r1 = 80000000
    rtype(F_SRA, 0, 1, 4, 4);
    check("sra_wb_valid", wb_valid, 1);
    check("sra_wb_num", wb_num, 4);
    check("sra_wb_data", wb_data, 32'hF800_0000);
    rtype(F_SRL, 0, 1, 5, 4);
    check("srl_wb_valid", wb_valid, 1);
    check("srl_wb_num", wb_num, 5);
    check("srl_wb_data", wb_data, 32'h0800_0000);
    @(posedge clk); #1;
    check("b2b_wb_done", wb_valid, 0);

    rtype(F_SLL, 0, 8, 1, 16);  // r1 = 10000
    rtype(F_OR, 1, 8, 2, 0);    // r2 = 10001
    rtype(F_MUL, 1, 2, 6, 0);
    check("mul_busy", busy, 1);
    check("mul_ready", instr_ready, 0);
    check("mul_no_wb_early", wb_valid, 0);
    opcode = 6'h00; func = F_ADD; rs_num = 1; rt_num = 1; rd_num = 7; sh_amount = 0;
    instr_valid = 1'b1;
    wait_iter(cyc);
    instr_valid = 1'b0;
    check("mul_busy_cycles", cyc, 32);
    check("mul_wb_valid", wb_valid, 1);
    check("mul_wb_num", wb_num, 6);
    check("mul_wb_data", wb_data, 32'h0001_0000);
    check("mul_ready_back", instr_ready, 1);
    check_reg("mul_blocked_r7", 7, 32'd0);

    rtype(F_SLL, 0, 8, 10, 6);  // 64
    rtype(F_SLL, 0, 8, 11, 5);  // 32
    rtype(F_SLL, 0, 8, 12, 2);  // 4
    rtype(F_OR, 10, 11, 10, 0);
    rtype(F_OR, 10, 12, 10, 0); // r10 = 100
    rtype(F_SRL, 0, 4, 15, 29); // r15 = 7
    rtype(F_DIV, 10, 15, 7, 0);
    wait_iter(cyc);
    check("div_busy_cycles", cyc, 32);
    check("div_wb_num", wb_num, 7);
    check("div_wb_data", wb_data, 14);
    check_reg("div_dbg_r7", 7, 32'd14);

    rtype(F_DIV, 10, 0, 16, 0);
    wait_iter(cyc);
    check("div0_wb_valid", wb_valid, 1);
    check("div0_wb_data", wb_data, 32'hFFFF_FFFF);

    rtype(F_ADD, 10, 10, 0, 0);
    check("rd0_wb_valid", wb_valid, 1);
    check("rd0_wb_num", wb_num, 0);
    check("rd0_wb_data", wb_data, 200);
    check_reg("rd0_dbg_r0", 0, 32'd0);

    send(6'h23, F_ADD, 10, 10, 17, 0);
    check("illop_pulse", illegal_op, 1);
    check("illop_no_wb", wb_valid, 0);
    check("illop_ready", instr_ready, 1);
    rtype(6'h01, 10, 10, 17, 0);
    check("illfunc_pulse", illegal_op, 1);
    @(posedge clk); #1;
    check("illop_clear", illegal_op, 0);
    check_reg("illop_r17", 17, 32'd0);

    rtype(F_SYS, 0, 0, 0, 0);
    check("sys_halted", halted, 1);
    check("sys_ready", instr_ready, 0);
    check("sys_no_wb", wb_valid, 0);
    opcode = 6'h00; func = F_ADD; rs_num = 10; rt_num = 10; rd_num = 18; sh_amount = 0;
    instr_valid = 1'b1;
    watch_wb(5, seen);
    instr_valid = 1'b0;
    check("halt_ignores", seen, 0);
    check("halt_sticky", halted, 1);
    check_reg("halt_r18", 18, 32'd0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("unhalt", halted, 0);
    check("unhalt_ready", instr_ready, 1);
    check_reg("rst_r10", 10, 32'd0);
    check_reg("rst_r7", 7, 32'd0);

    rtype(F_NOR, 0, 0, 1, 0);   // ffffffff
    rtype(F_SRL, 0, 1, 2, 1);   // 7fffffff
    rtype(F_SRL, 0, 1, 3, 31);  // 1
    rtype(F_ADD, 2, 3, 4, 0);
`ifdef OVF_TRAP_EN
    check("ovf_trap", ovf_trap, 1);
    check("ovf_no_wb", wb_valid, 0);
    check("ovf_count", ovf_count, 1);
    check_reg("ovf_r4", 4, 32'd0);
    @(posedge clk); #1;
    check("ovf_trap_clear", ovf_trap, 0);
`else
    check("wrap_wb_valid", wb_valid, 1);
    check("wrap_wb_data", wb_data, 32'h8000_0000);
    check_reg("wrap_r4", 4, 32'h8000_0000);
`endif

    rtype(F_DIV, 0, 0, 1, 0);
    check("abort_busy", busy, 1);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy_clr", busy, 0);
    check("abort_ready", instr_ready, 1);
    watch_wb(40, seen);
    check("abort_no_wb", seen, 0);
    check_reg("abort_r1", 1, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rtype_exec_unit.md
Name: rtype_exec_unit

Overview:
- Parametrised R-type execute stage for the MIPS core: register file, single-cycle ALU, and an iterative unsigned multiplier/divider behind a valid/ready instruction handshake.
- Accepts decoded fields (opcode, func, rs/rt/rd numbers, shamt), reads operands, computes, and writes back to rd.
- Replaces the flat combinational datapath with data width and register count as parameters, multi-cycle MUL/DIV with backpressure, shifts, halt, and illegal-op reporting.

Parameters:
- DATA_W, 32, datapath and register width; must be ≥ 8.
- REG_NUM, 32, number of architectural registers; power of two, ≥ 4. Register 0 reads as zero and ignores writes.
- REG_AW, $clog2(REG_NUM), register-number width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction fields valid this cycle.
- instr_ready  out  1  unit can accept; transfer on the edge where valid && ready.
- opcode  in  6  must be 0 (R-type).
- func  in  6  operation select.
- rs_num, rt_num, rd_num  in  REG_AW each  source/destination registers.
- sh_amount  in  5  shift amount; shifts use sh_amount mod DATA_W.
- wb_valid  out  1  one-cycle pulse: result written to rd this cycle's preceding edge.
- wb_num  out  REG_AW  rd of the reported write.
- wb_data  out  DATA_W  value written.
- busy  out  1  iterative MUL/DIV in progress.
- illegal_op  out  1  one-cycle pulse: accepted instruction was not legal.
- halted  out  1  sticky; set by SYSCALL.
- dbg_num  in  REG_AW  debug read address.
- dbg_data  out  DATA_W  combinational register read (0 for register 0).

Behaviour:
- Reset: every register 0; state IDLE; instr_ready=1 on the cycle after reset deasserts; wb_valid, wb_num, wb_data, busy, illegal_op, halted all 0. Reset mid-iteration aborts with no write-back.
- Operands are combinational reads of rs/rt at acceptance; an earlier write is visible to the next instruction with no hazard.
- Single-cycle funcs (opcode 0):
  - ADD 0x20 and SUB 0x22 wrap modulo 2^DATA_W.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLL 0x00, SRL 0x02, SRA 0x03 shift rt.
- Single-cycle timing: accepted on edge k; rd written on edge k; wb_valid=1 with wb_num/wb_data during cycle k+1. instr_ready stays 1, giving throughput one per cycle.
- MUL 0x18: low DATA_W bits of the unsigned product rs*rt.
- DIV 0x1A: unsigned quotient rs/rt; rt=0 gives all-ones.
- MUL/DIV sequence:
  - Accepted on edge k → ITER state; busy=1 and instr_ready=0 from cycle k+1.
  - Shift-add or restoring divide runs one bit per edge, with counter 0..DATA_W-1.
  - rd is written on edge k+DATA_W; wb_valid pulses in the following cycle.
  - busy deasserts and instr_ready reasserts in that same cycle.
- rd_num=0: the op executes and wb_valid pulses with wb_num=0 and the computed wb_data; the register file is unchanged.
- SYSCALL 0x0C: no write. State HALT; halted=1 and instr_ready=0 from the next cycle until rst.
- Illegal: opcode≠0 or unlisted func. No write; illegal_op pulses in the next cycle; instr_ready stays 1.
- States: IDLE→ITER (MUL/DIV accepted), IDLE→HALT (SYSCALL), ITER→IDLE (counter=DATA_W-1), HALT→IDLE only via rst. instr_valid is ignored outside IDLE.

Optional Feature:
- Macro: OVF_TRAP_EN.
- Defined:
  - Signed overflow on ADD/SUB suppresses the rd write and wb_valid.
  - Adds output port ovf_trap (1 bit), which pulses in the cycle after acceptance.
  - Also adds output ovf_count (16 bits), saturating at 0xFFFF and cleared by rst.
- Undefined: ADD/SUB wrap silently; no extra ports.

Test Plan (DATA_W=32, REG_NUM=32):
- Preload via chained ops from reset zeros (XOR/NOR/SLL sequences) so r1=5, r2=7. Then ADD r3=r1+r2 → wb_valid next cycle, wb_num=3, wb_data=12, dbg_data(r3)=12.
- r1=0x80000000: SRA r4,r1,4 → 0xF8000000; SRL r5,r1,4 → 0x08000000. Issue them back-to-back with no gap → two consecutive wb_valid pulses.
- MUL r6=r1*r2 with r1=0x10000, r2=0x10001 → busy=1 for 32 cycles, instr_ready=0, wb_data=0x00010000 (low word). An instruction presented during busy is not accepted.
- DIV: r7=100/7 → 14. DIV by r0 → 0xFFFFFFFF. Write to rd=0 → dbg_data(r0)=0.
- opcode=0x23 → illegal_op pulse, no wb_valid. SYSCALL → halted=1, instr_ready=0 held; rst clears halted and all registers.
- Assert rst in cycle 10 of a DIV → no wb_valid, busy=0 afterwards, state IDLE. With OVF_TRAP_EN: ADD of 0x7FFFFFFF+1 → ovf_trap pulse, rd unchanged, ovf_count=1.
